// File: rtl/cam_view_addr.sv
// cam_view_addr: read-side view generator for the camera frame buffer.
// Maps VGA screen positions to frame RAM read addresses with integer
// upscaling, a movable window, a border colour and double-buffered banks.
// The pipeline has a fixed latency of 3 + RAM_LAT cycles from request to pixel.
module cam_view_addr #(
  parameter int CAM_SCREEN_X = 160,
  parameter int CAM_SCREEN_Y = 120,
  parameter int AW           = 15,
  parameter int DW           = 8,
  parameter int XW           = 10,
  parameter int YW           = 9,
  parameter int RAM_LAT      = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pos_valid,
  input  logic [XW-1:0] VGA_posX,
  input  logic [YW-1:0] VGA_posY,
  input  logic [1:0]    scale_sel,
  input  logic [XW-1:0] off_x,
  input  logic [YW-1:0] off_y,
  input  logic [DW-1:0] border_color,
  input  logic          swap_req,
  output logic [AW:0]   ram_addr,
  input  logic [DW-1:0] ram_rdata,
  output logic [DW-1:0] px_out,
  output logic          px_valid,
  output logic          disp_bank,
  output logic          swap_done,
  output logic [7:0]    frame_cnt
);

  localparam logic [XW:0] CAM_X_L = (XW+1)'(CAM_SCREEN_X);
  localparam logic [YW:0] CAM_Y_L = (YW+1)'(CAM_SCREEN_Y);

  logic          frame_start;
  logic [1:0]    cfg_scale;
  logic [XW-1:0] cfg_off_x;
  logic [YW-1:0] cfg_off_y;
  logic [DW-1:0] cfg_border;
  logic          swap_pend;

  logic [1:0]    eff_scale;
  logic [XW-1:0] eff_off_x;
  logic [YW-1:0] eff_off_y;
  logic [DW-1:0] eff_border;

  logic [1:0]    shamt;
  logic [XW:0]   rx;
  logic [YW:0]   ry;
  logic [XW:0]   cx;
  logic [YW:0]   cy;
  logic          inwin;

  logic          s1_valid;
  logic          s1_inwin;
  logic [XW-1:0] s1_cx;
  logic [YW-1:0] s1_cy;
  logic [DW-1:0] s1_border;
  logic [AW-1:0] pix_idx;

  logic          dl_valid  [0:RAM_LAT];
  logic          dl_inwin  [0:RAM_LAT];
  logic [DW-1:0] dl_border [0:RAM_LAT];

  assign frame_start = pos_valid && (VGA_posX == '0) && (VGA_posY == '0);

  // The frame-start pixel must already see the new configuration, so the
  // live inputs bypass the latches on that one cycle.
  always_comb begin
    eff_scale  = frame_start ? scale_sel    : cfg_scale;
    eff_off_x  = frame_start ? off_x        : cfg_off_x;
    eff_off_y  = frame_start ? off_y        : cfg_off_y;
    eff_border = frame_start ? border_color : cfg_border;
  end

  // Per-frame configuration latch, swap bookkeeping and frame counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_scale  <= 2'd0;
      cfg_off_x  <= '0;
      cfg_off_y  <= '0;
      cfg_border <= '0;
      swap_pend  <= 1'b0;
      disp_bank  <= 1'b0;
      swap_done  <= 1'b0;
      frame_cnt  <= 8'd0;
    end else if (frame_start) begin
      cfg_scale  <= scale_sel;
      cfg_off_x  <= off_x;
      cfg_off_y  <= off_y;
      cfg_border <= border_color;
      frame_cnt  <= frame_cnt + 8'd1;
      if (swap_pend || swap_req) begin
        disp_bank <= ~disp_bank;
        swap_done <= 1'b1;
        swap_pend <= 1'b0;
      end else begin
        swap_done <= 1'b0;
      end
    end else begin
      swap_done <= 1'b0;
      if (swap_req) swap_pend <= 1'b1;
    end
  end

  // Stage 1 combinational: window-relative coordinates, one bit wider so a
  // position left of / above the origin shows up as a set MSB.
  always_comb begin
    case (eff_scale)
      2'd1:    shamt = 2'd1;
      2'd2:    shamt = 2'd2;
      default: shamt = 2'd0;
    endcase
    rx    = {1'b0, VGA_posX} - {1'b0, eff_off_x};
    ry    = {1'b0, VGA_posY} - {1'b0, eff_off_y};
    cx    = rx >> shamt;
    cy    = ry >> shamt;
    inwin = ~rx[XW] && ~ry[YW] && (cx < CAM_X_L) && (cy < CAM_Y_L);
  end

  // Stage 1 register: reduced coordinates and window flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_inwin  <= 1'b0;
      s1_cx     <= '0;
      s1_cy     <= '0;
      s1_border <= '0;
    end else begin
      s1_valid  <= pos_valid;
      s1_inwin  <= inwin;
      s1_cx     <= cx[XW-1:0];
      s1_cy     <= cy[YW-1:0];
      s1_border <= eff_border;
    end
  end

  // Linear index; the window compare guarantees it fits in AW bits.
  assign pix_idx = AW'(s1_cy) * AW'(CAM_SCREEN_X) + AW'(s1_cx);

  // Stage 2: RAM address, holding when the pixel is border or idle.
  // disp_bank is already updated for the frame-start pixel here.
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_addr <= '0;
    end else if (s1_valid && s1_inwin) begin
      ram_addr <= {disp_bank, pix_idx};
    end
  end

  // Delay line carrying valid/inwin/border alongside the RAM access.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k <= RAM_LAT; k++) begin
        dl_valid[k]  <= 1'b0;
        dl_inwin[k]  <= 1'b0;
        dl_border[k] <= '0;
      end
    end else begin
      dl_valid[0]  <= s1_valid;
      dl_inwin[0]  <= s1_inwin;
      dl_border[0] <= s1_border;
      for (int k = 1; k <= RAM_LAT; k++) begin
        dl_valid[k]  <= dl_valid[k-1];
        dl_inwin[k]  <= dl_inwin[k-1];
        dl_border[k] <= dl_border[k-1];
      end
    end
  end

  // Output stage: RAM data inside the window, border outside, hold when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      px_out   <= '0;
      px_valid <= 1'b0;
    end else begin
      px_valid <= dl_valid[RAM_LAT];
      if (dl_valid[RAM_LAT]) begin
        px_out <= dl_inwin[RAM_LAT] ? ram_rdata : dl_border[RAM_LAT];
      end
    end
  end

endmodule
